// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: takes a word over valid/ready and shifts it out LSB-first,
// advancing one bit per upstream baud tick (start, data, optional parity, stop bits).
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done,
    output logic [2:0]           dbg_state
);

    // Handshake: a word is taken on the rising edge where in_valid && in_ready;
    // in_ready is high exactly when the FSM is IDLE, and in_data is not looked at otherwise.

    localparam int CNT_W = $clog2(DATA_BITS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             ODD_BIT   = (PARITY_ODD != 0);
    localparam logic             USE_PAR   = (PARITY_EN != 0);

    logic [2:0]           state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
    logic                 stopcnt_q, stopcnt_d;
    logic                 parity_q, parity_d;
    logic                 accept;

    assign accept = in_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        stopcnt_d = stopcnt_q;
        parity_d  = parity_q;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                // Ticks here are ignored: the first usable tick must arrive in WAIT.
                if (accept) begin
                    shreg_d  = in_data;
                    parity_d = (^in_data) ^ ODD_BIT;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    tx_d     = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = '0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bitcnt_q == LAST_BIT) begin
                        // Cleared on both exits so a 2-stop frame never inherits a stale count.
                        stopcnt_d = 1'b0;
                        if (USE_PAR) begin
                            tx_d    = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        tx_d     = shreg_q[0];
                        shreg_d  = shreg_q >> 1;
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    tx_d      = 1'b1;
                    stopcnt_d = 1'b0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (stopcnt_q == STOP_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stopcnt_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            stopcnt_q <= 1'b0;
            parity_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            stopcnt_q <= stopcnt_d;
            parity_q  <= parity_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign tx        = tx_q;
    assign tx_done   = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three framings (8N1, 8E2, 8O1) checked clock-by-clock
// against a queue of expected {in_ready, tx_done, tx} samples built from each accepted word.
module tb_uart_tx_serializer;

    localparam int W = 3;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DATA = 3'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic [2:0] in_valid_v;
    logic [7:0] in_data;
    logic [2:0] tx_v, busy_v, ready_v, done_v;
    logic [2:0] dbg_v [3];

    logic [1:0] sel = 2'd0;
    logic       tx_s, busy_s, ready_s, done_s;
    logic [2:0] dbg_s;

    int checks = 0;
    int failures = 0;
    int period = 4;
    int tick_cnt = 0;
    bit tick_on = 1'b0;
    bit last_edge_tick = 1'b0;

    logic [W-1:0] exp_q[$];
    int           len_q[$];
    bit active = 1'b0;
    int left = 0;
    int idle_run = 0;
    bit gap_chk = 1'b0;
    int exp_gap = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_valid(in_valid_v[0]), .in_data(in_data),
        .in_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]), .dbg_state(dbg_v[0]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_valid(in_valid_v[1]), .in_data(in_data),
        .in_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]), .dbg_state(dbg_v[1]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_valid(in_valid_v[2]), .in_data(in_data),
        .in_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]), .dbg_state(dbg_v[2]));

    assign tx_s    = tx_v[sel];
    assign busy_s  = busy_v[sel];
    assign ready_s = ready_v[sel];
    assign done_s  = done_v[sel];
    assign dbg_s   = dbg_v[sel];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Tick source: one pulse every `period` clocks, or held high when period is 1.
    always @(negedge clk) begin
        if (!tick_on) begin
            baud_tick = 1'b0;
        end else if (period <= 1) begin
            baud_tick = 1'b1;
        end else begin
            tick_cnt  = (tick_cnt + 1) % period;
            baud_tick = (tick_cnt == 0);
        end
    end

    always @(posedge clk) last_edge_tick = baud_tick;

    // Reference frame: start, LSB-first data, optional parity, stop bits; each bit `period` clocks.
    task automatic push_frame(input logic [7:0] d);
        logic line[$];
        bit   par_en;
        bit   odd;
        int   stops;
        par_en = (sel != 2'd0);
        odd    = (sel == 2'd2);
        stops  = (sel == 2'd1) ? 2 : 1;
        line.push_back(1'b0);
        for (int i = 0; i < 8; i++) line.push_back(d[i]);
        if (par_en) line.push_back((^d) ^ odd);
        for (int s = 0; s < stops; s++) line.push_back(1'b1);
        foreach (line[k]) begin
            for (int r = 0; r < period; r++) exp_q.push_back({1'b0, 1'b0, line[k]});
        end
        exp_q.push_back(3'b111);
        len_q.push_back(line.size() * period + 1);
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst) begin
            active = 1'b0;
            exp_q.delete();
            len_q.delete();
            idle_run = 0;
        end else begin
            if (!active && tx_s == 1'b0) begin
                check("frame_expected", len_q.size() != 0, 1);
                check("start_latency", last_edge_tick, 1);
                if (gap_chk) begin
                    check("b2b_idle_clks", idle_run, exp_gap);
                    gap_chk = 1'b0;
                end
                if (len_q.size() != 0) begin
                    active = 1'b1;
                    left   = len_q.pop_front();
                end
            end
            if (active) begin
                e = exp_q.pop_front();
                check("tx_bit", tx_s, e[0]);
                check("tx_done", done_s, e[1]);
                check("in_ready", ready_s, e[2]);
                check("busy", busy_s, !e[2]);
                left--;
                if (left == 0) begin
                    active   = 1'b0;
                    idle_run = 0;
                end
            end else begin
                idle_run++;
                check("idle_done", done_s, 0);
            end
        end
    end

    task automatic send_word(input logic [7:0] d, input bit keep);
        int b;
        b = 0;
        in_data         = d;
        in_valid_v[sel] = 1'b1;
        while (!ready_s && b < 2000) begin
            @(negedge clk);
            b++;
        end
        check("accept_timeout", b < 2000, 1);
        push_frame(d);
        @(negedge clk);
        if (!keep) in_valid_v[sel] = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || active) && b < 5000) begin
            @(negedge clk);
            b++;
        end
        check("drain_timeout", b < 5000, 1);
    endtask

    initial begin
        int b;
        in_valid_v = '0;
        in_data    = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_s, 1);
        check("rst_busy", busy_s, 0);
        check("rst_ready", ready_s, 1);
        check("rst_done", done_s, 0);
        check("rst_state", dbg_s, ST_IDLE);
        rst = 1'b0;
        @(negedge clk);
        tick_on = 1'b1;

        // 8N1, tick every 4 clocks
        send_word(8'h55, 1'b0);
        drain();
        for (int i = 0; i < 3; i++) begin
            send_word(8'($urandom_range(0, 255)), 1'b0);
            drain();
        end

        // even parity with two stop bits, then odd parity
        sel = 2'd1;
        send_word(8'h07, 1'b0);
        drain();
        send_word(8'($urandom_range(0, 255)), 1'b0);
        drain();
        sel = 2'd2;
        send_word(8'h07, 1'b0);
        drain();
        send_word(8'($urandom_range(0, 255)), 1'b0);
        drain();

        // valid held through the frame with data changing; second word goes back-to-back
        sel = 2'd0;
        send_word(8'h3C, 1'b1);
        b = 0;
        while (!active && b < 500) begin
            @(negedge clk);
            b++;
        end
        check("first_frame_start", active, 1);
        exp_gap = period - 1;
        gap_chk = 1'b1;
        repeat (8) @(negedge clk);
        in_data = 8'h99;
        repeat (8) @(negedge clk);
        send_word(8'hC3, 1'b0);
        drain();
        check("gap_seen", gap_chk, 0);

        // tick held high: idle ticks do nothing, then one bit per clock
        period = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_tick_tx", tx_s, 1);
            check("idle_tick_state", dbg_s, ST_IDLE);
        end
        send_word(8'hA3, 1'b0);
        drain();

        // reset in the middle of the data bits
        period = 4;
        send_word(8'h5A, 1'b0);
        b = 0;
        while (dbg_s != ST_DATA && b < 500) begin
            @(negedge clk);
            b++;
        end
        check("reach_data", dbg_s, ST_DATA);
        #2;
        rst = 1'b1;
        #1;
        check("abort_tx", tx_s, 1);
        check("abort_busy", busy_s, 0);
        check("abort_ready", ready_s, 1);
        check("abort_done", done_s, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_done_hold", done_s, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_abort_tx", tx_s, 1);
        end
        send_word(8'h81, 1'b0);
        drain();

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
